asg_seg_sched: RTL

ASG_SEG_SCHED -- requirements
Module: asg_seg_sched

---
 rtl/asg_seg_sched_if.sv | 35 +++
 rtl/asg_seg_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/asg_seg_sched_if.sv
// Bundle of control/status signals between the segment scheduler and its
// host/datapath. Signal names keep the scheduler's view (_i into it, _o out).
//   master : host/datapath side (drives arm/stop/trig/config/done/ack)
//   slave  : scheduler side (drives seg_sel/seg_start/run/state/buf_free/err)
interface asg_seg_sched_if #(
  parameter int unsigned NSEG = 4,
  parameter int unsigned CW   = 16
) ();
  localparam int unsigned SelW = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic               arm_i;
  logic               stop_i;
  logic               trig_i;
  logic [NSEG-1:0]    seg_en_i;
  logic [NSEG*CW-1:0] seg_cyc_i;
  logic               loop_i;
  logic               seg_done_i;
  logic [NSEG-1:0]    buf_ack_i;
  logic [SelW-1:0]    seg_sel_o;
  logic               seg_start_o;
  logic               run_o;
  logic [1:0]         state_o;
  logic [NSEG-1:0]    buf_free_o;
  logic               err_o;

  modport master (
    output arm_i, stop_i, trig_i, seg_en_i, seg_cyc_i, loop_i, seg_done_i, buf_ack_i,
    input  seg_sel_o, seg_start_o, run_o, state_o, buf_free_o, err_o
  );

  modport slave (
    input  arm_i, stop_i, trig_i, seg_en_i, seg_cyc_i, loop_i, seg_done_i, buf_ack_i,
    output seg_sel_o, seg_start_o, run_o, state_o, buf_free_o, err_o
  );
endinterface

// File: rtl/asg_seg_sched.sv
// Waveform segment scheduler: steps through enabled segments, playing each
// seg_cyc table passes, then marks its buffer free for the host to refill.
// Ports:
//   dac_clk_i  : clock, rising edge
//   dac_rstn_i : asynchronous active-low reset
//   bus        : asg_seg_sched_if slave modport
//     in : arm_i, stop_i, trig_i, seg_en_i, seg_cyc_i, loop_i, seg_done_i, buf_ack_i
//     out: seg_sel_o, seg_start_o, run_o, state_o, buf_free_o, err_o
module asg_seg_sched #(
  parameter int unsigned NSEG = 4,
  parameter int unsigned CW   = 16
) (
  input  logic           dac_clk_i,
  input  logic           dac_rstn_i,
  asg_seg_sched_if.slave bus
);
  localparam int unsigned SelW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e          state_q;
  logic [SelW-1:0] sel_q;
  logic            start_q;
  logic [CW-1:0]   cnt_q;
  logic [NSEG-1:0] buf_free_q;
  logic            err_q;
  logic            trig_q;

  logic            trig_edge;
  logic            lo_found, nx_found;
  logic [SelW-1:0] lo_idx, nx_idx;
  logic [CW-1:0]   cur_cyc, last_cnt;
  logic            last_pass;
  logic [NSEG-1:0] bf_set;

  assign trig_edge = bus.trig_i & ~trig_q;

  // Lowest enabled segment, and lowest enabled segment above the current one.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    nx_found = 1'b0;
    nx_idx   = '0;
    cur_cyc  = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      if (bus.seg_en_i[k]) begin
        lo_found = 1'b1;
        lo_idx   = SelW'(k);
        if (k > int'(sel_q)) begin
          nx_found = 1'b1;
          nx_idx   = SelW'(k);
        end
      end
      if (SelW'(k) == sel_q) cur_cyc = bus.seg_cyc_i[k*CW +: CW];
    end
  end

  // A programmed count of 0 plays one pass, same as 1.
  assign last_cnt  = (cur_cyc == '0) ? '0 : cur_cyc - CW'(1);
  assign last_pass = (cnt_q == last_cnt);

  always_comb begin
    bf_set = '0;
    if (state_q == StRun && bus.seg_done_i && last_pass && !bus.stop_i) bf_set[sel_q] = 1'b1;
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      buf_free_q <= '0;
      err_q      <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      trig_q     <= bus.trig_i;
      start_q    <= 1'b0;
      // A completion in the same cycle as the host ack re-frees the buffer.
      buf_free_q <= (buf_free_q & ~bus.buf_ack_i) | bf_set;
      // Underrun: a segment restarts before the host refilled its buffer.
      if (start_q && buf_free_q[sel_q] && !bus.buf_ack_i[sel_q]) err_q <= 1'b1;

      if (bus.stop_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.arm_i && (bus.seg_en_i != '0)) begin
              state_q <= StArmed;
              err_q   <= 1'b0;
            end
          end
          StArmed: begin
            if (trig_edge) begin
              cnt_q <= '0;
              if (lo_found) begin
                state_q <= StRun;
                sel_q   <= lo_idx;
                start_q <= 1'b1;
              end else begin
                state_q <= StDone;
              end
            end
          end
          StRun: begin
            if (bus.seg_done_i) begin
              if (last_pass) begin
                cnt_q <= '0;
                if (nx_found) begin
                  sel_q   <= nx_idx;
                  start_q <= 1'b1;
                end else if (bus.loop_i && lo_found) begin
                  sel_q   <= lo_idx;
                  start_q <= 1'b1;
                end else begin
                  state_q <= StDone;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          StDone: begin
            if (bus.arm_i) begin
              state_q <= StArmed;
              err_q   <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.seg_sel_o   = sel_q;
  assign bus.seg_start_o = start_q;
  assign bus.run_o       = (state_q == StRun);
  assign bus.state_o     = state_q;
  assign bus.buf_free_o  = buf_free_q;
  assign bus.err_o       = err_q;
endmodule
